// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receiver/sender state encoding, defaults and idle line level.
package uart_pkg;
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4,
      BREAK  = 3'd5
   } uart_state_t;
   localparam int   DATA_BITS_DEF  = 8;
   localparam int   OVERSAMPLE_DEF = 4;
   localparam logic IDLE_LEVEL     = 1'b1;
endpackage

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchronizer that resets to the idle line level.
module uart_sync2
   import uart_pkg::*;
(
   input  logic clk,
   input  logic clr,
   input  logic i_d,
   output logic o_q
);
   logic [1:0] r_sync;
   // shift the asynchronous line through two flops
   always_ff @(posedge clk or negedge clr)
      if (!clr) r_sync <= {2{IDLE_LEVEL}};
      else r_sync <= {r_sync[0], i_d};
   assign o_q = r_sync[1];
endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: oversampled 8N1 UART receiver with REQ/ACK delivery and error flags.
// Optional even-parity check is compiled in by defining UART_RECEIVER_PARITY_EN.
module uart_receiver
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE = OVERSAMPLE_DEF,
   parameter int DATA_BITS  = DATA_BITS_DEF
) (
   input  logic                 clk,
   input  logic                 clr,
   input  logic                 RCV,
   output logic [DATA_BITS-1:0] RCV_DATA,
   output logic                 RCV_REQ,
   input  logic                 RCV_ACK,
   output logic                 FRM_ERR,
   output logic                 OVR_ERR,
   output logic                 PAR_ERR
);
   localparam int TW = $clog2(OVERSAMPLE);
   localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

   uart_state_t          r_state, w_next;
   logic                 w_rx_s;
   logic [TW-1:0]        r_tick;
   logic [BW-1:0]        r_bit;
   logic [DATA_BITS-1:0] r_shift, r_data;
   logic                 r_req, r_ovr, r_frm;
   logic                 w_last, w_tick_clr, w_shift, w_stop, w_par_bad, w_deliver, w_ack;

   uart_sync2 u_sync (.clk(clk), .clr(clr), .i_d(RCV), .o_q(w_rx_s));

   assign w_last    = (r_tick == TICK_LAST);
   assign w_deliver = w_stop & w_rx_s & ~w_par_bad;
   assign w_ack     = r_req & RCV_ACK;

`ifdef UART_RECEIVER_PARITY_EN
   localparam uart_state_t DATA_NEXT = PARITY;
   logic r_par_bad, r_par;
   // latch the even-parity mismatch at the parity sample and report it with the stop sample
   always_ff @(posedge clk or negedge clr)
      if (!clr) begin
         r_par_bad <= 1'b0;
         r_par     <= 1'b0;
      end else begin
         r_par_bad <= (r_state == PARITY && w_last) ? ^{r_shift, w_rx_s} : r_par_bad;
         r_par     <= w_stop & r_par_bad;
      end
   assign w_par_bad = r_par_bad;
   assign PAR_ERR   = r_par;
`else
   localparam uart_state_t DATA_NEXT = STOP;
   assign w_par_bad = 1'b0;
   assign PAR_ERR   = 1'b0;
`endif

   // state register
   always_ff @(posedge clk or negedge clr)
      if (!clr) r_state <= IDLE;
      else r_state <= w_next;

   // next state and per-cycle strobes for the counters and datapath
   always_comb begin
      w_next     = r_state;
      w_tick_clr = 1'b0;
      w_shift    = 1'b0;
      w_stop     = 1'b0;
      case (r_state)
         IDLE: begin
            w_tick_clr = ~w_rx_s;
            w_next     = w_rx_s ? IDLE : START;
         end
         START: if (r_tick == TICK_MID) begin
            w_tick_clr = 1'b1;
            w_next     = w_rx_s ? IDLE : DATA;
         end
         DATA: if (w_last) begin
            w_tick_clr = 1'b1;
            w_shift    = 1'b1;
            w_next     = (r_bit == BIT_LAST) ? DATA_NEXT : DATA;
         end
         PARITY: if (w_last) begin
            w_tick_clr = 1'b1;
            w_next     = STOP;
         end
         STOP: if (w_last) begin
            w_tick_clr = 1'b1;
            w_stop     = 1'b1;
            w_next     = w_rx_s ? IDLE : BREAK;
         end
         BREAK: w_next = w_rx_s ? IDLE : BREAK;
         default: w_next = IDLE;
      endcase
   end

   // tick counter runs freely and wraps at one bit time; bit counter only advances inside DATA
   always_ff @(posedge clk or negedge clr)
      if (!clr) begin
         r_tick <= '0;
         r_bit  <= '0;
      end else begin
         r_tick <= (w_tick_clr || w_last) ? '0 : r_tick + 1'b1;
         r_bit  <= (r_state != DATA) ? '0 : r_bit + BW'(w_shift);
      end

   // shift in LSB first, deliver on the stop sample; an ACK in the same cycle frees the holding register
   always_ff @(posedge clk or negedge clr)
      if (!clr) begin
         r_shift <= '0;
         r_data  <= '0;
         r_req   <= 1'b0;
         r_ovr   <= 1'b0;
         r_frm   <= 1'b0;
      end else begin
         r_shift <= w_shift ? {w_rx_s, r_shift[DATA_BITS-1:1]} : r_shift;
         r_data  <= (w_deliver && (!r_req || w_ack)) ? r_shift : r_data;
         r_req   <= w_deliver | (r_req & ~w_ack);
         r_ovr   <= (r_ovr | (w_deliver & r_req)) & ~w_ack;
         r_frm   <= w_stop & ~w_rx_s;
      end

   assign RCV_DATA = r_data;
   assign RCV_REQ  = r_req;
   assign OVR_ERR  = r_ovr;
   assign FRM_ERR  = r_frm;
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: table, hand-written corner and randomized checks of uart_receiver.
module tb_uart_receiver;
   localparam int OS    = 4;
   localparam int DB    = 8;
   localparam int FRAME = (DB + 2) * OS;
   localparam int LAT   = 2 + OS / 2 + (DB + 1) * OS + 1;
   localparam int NR    = 30;

   typedef struct {
      logic [7:0] d;
      logic       stop;
      logic       exp_req;
      int         exp_frm;
   } vec_t;

   logic          clk = 1'b0, clr = 1'b0, RCV = 1'b1, RCV_ACK = 1'b0;
   logic [DB-1:0] RCV_DATA;
   logic          RCV_REQ, FRM_ERR, OVR_ERR, PAR_ERR;
   int            total = 0, bad = 0, frm_seen = 0, req_rises = 0;
   logic          req_q = 1'b0;
   logic [7:0]    exp_q[$];
   vec_t          vecs[8];

   uart_receiver #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
      .clk(clk), .clr(clr), .RCV(RCV), .RCV_DATA(RCV_DATA), .RCV_REQ(RCV_REQ),
      .RCV_ACK(RCV_ACK), .FRM_ERR(FRM_ERR), .OVR_ERR(OVR_ERR), .PAR_ERR(PAR_ERR)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (FRM_ERR) frm_seen++;
      if (RCV_REQ && !req_q) req_rises++;
      req_q = RCV_REQ;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endfunction

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drive(input logic v, input int n);
      RCV = v;
      step(n);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop);
      drive(1'b0, OS);
      for (int i = 0; i < DB; i++) drive(d[i], OS);
      drive(stop, OS);
      RCV = 1'b1;
   endtask

   task automatic expect_byte(input string nm, input logic [7:0] d);
      chk({nm, " req"}, RCV_REQ, 1);
      chk({nm, " data"}, RCV_DATA, d);
      chk({nm, " ovr"}, OVR_ERR, 0);
      RCV_ACK = 1'b1;
      step(1);
      RCV_ACK = 1'b0;
      chk({nm, " ack drop"}, RCV_REQ, 0);
   endtask

   task automatic consume(input int n, input int budget);
      int got = 0;
      int t = 0;
      while (got < n && t < budget) begin
         @(negedge clk);
         t++;
         if (RCV_REQ) begin
            repeat ($urandom_range(0, 20)) begin
               @(negedge clk);
               t++;
            end
            chk("rand ovr", OVR_ERR, 0);
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL rand extra byte: got %0h want none", RCV_DATA);
            end else chk("rand data", RCV_DATA, exp_q.pop_front());
            RCV_ACK = 1'b1;
            @(negedge clk);
            t++;
            RCV_ACK = 1'b0;
            got++;
         end
      end
      chk("rand count", got, n);
   endtask

   initial begin
      int lat, f0, r0, nbad, nfr;
      logic [7:0] rd[NR];
      logic       rs[NR];
      int         rg[NR];
      vecs[0] = '{8'h61, 1'b1, 1'b1, 0};
      vecs[1] = '{8'hA5, 1'b0, 1'b0, 1};
      vecs[2] = '{8'h3C, 1'b1, 1'b1, 0};
      vecs[3] = '{8'h00, 1'b1, 1'b1, 0};
      vecs[4] = '{8'hFF, 1'b1, 1'b1, 0};
      vecs[5] = '{8'h80, 1'b0, 1'b0, 1};
      vecs[6] = '{8'h01, 1'b1, 1'b1, 0};
      vecs[7] = '{8'h55, 1'b1, 1'b1, 0};
      #12;
      chk("reset req", RCV_REQ, 0);
      chk("reset data", RCV_DATA, 0);
      chk("reset frm", FRM_ERR, 0);
      chk("reset ovr", OVR_ERR, 0);
      chk("reset par", PAR_ERR, 0);
      clr = 1'b1;
      step(4);
      // loopback byte with start-to-REQ latency
      f0 = frm_seen;
      lat = 0;
      fork
         send_frame(8'h61, 1'b1);
         while (!RCV_REQ && lat < 4 * FRAME) begin
            step(1);
            lat++;
         end
      join
      chk("loop latency", lat, LAT);
      chk("loop frm", frm_seen - f0, 0);
      expect_byte("loop", 8'h61);
      // one-cycle glitch is a false start
      r0 = req_rises;
      f0 = frm_seen;
      drive(1'b0, 1);
      drive(1'b1, 4 * OS);
      chk("glitch req", req_rises - r0, 0);
      chk("glitch frm", frm_seen - f0, 0);
      send_frame(8'h5A, 1'b1);
      drive(1'b1, 2 * OS);
      expect_byte("after glitch", 8'h5A);
      // framing error followed by a held-low line
      r0 = req_rises;
      f0 = frm_seen;
      send_frame(8'hA5, 1'b0);
      drive(1'b0, 3 * OS);
      drive(1'b1, 2 * OS);
      chk("frame frm", frm_seen - f0, 1);
      chk("frame req", req_rises - r0, 0);
      send_frame(8'h3C, 1'b1);
      drive(1'b1, 2 * OS);
      expect_byte("after break", 8'h3C);
      // table of single frames
      for (int i = 0; i < 8; i++) begin
         f0 = frm_seen;
         send_frame(vecs[i].d, vecs[i].stop);
         drive(1'b1, 2 * OS);
         chk($sformatf("vec%0d frm", i), frm_seen - f0, vecs[i].exp_frm);
         chk($sformatf("vec%0d req", i), RCV_REQ, vecs[i].exp_req);
         if (RCV_REQ) expect_byte($sformatf("vec%0d", i), vecs[i].d);
      end
      // overrun keeps the first byte
      send_frame(8'h11, 1'b1);
      drive(1'b1, OS);
      send_frame(8'h22, 1'b1);
      drive(1'b1, 2 * OS);
      chk("ovr req", RCV_REQ, 1);
      chk("ovr data", RCV_DATA, 8'h11);
      chk("ovr flag", OVR_ERR, 1);
      RCV_ACK = 1'b1;
      step(1);
      RCV_ACK = 1'b0;
      chk("ovr ack req", RCV_REQ, 0);
      chk("ovr ack flag", OVR_ERR, 0);
      // back-to-back frames, ACK on the cycle of the second delivery
      lat = 0;
      fork
         begin
            send_frame(8'h00, 1'b1);
            send_frame(8'hFF, 1'b1);
            drive(1'b1, 2 * OS);
         end
         begin
            while (!RCV_REQ && lat < 4 * FRAME) begin
               step(1);
               lat++;
            end
            chk("b2b first latency", lat, LAT);
            chk("b2b first data", RCV_DATA, 8'h00);
            step(FRAME - 1);
            chk("b2b held data", RCV_DATA, 8'h00);
            RCV_ACK = 1'b1;
            step(1);
            RCV_ACK = 1'b0;
            chk("b2b second req", RCV_REQ, 1);
            chk("b2b second data", RCV_DATA, 8'hFF);
            chk("b2b ovr", OVR_ERR, 0);
         end
      join
      expect_byte("b2b second", 8'hFF);
      // reset during bit 4 with a byte still pending
      send_frame(8'h3C, 1'b1);
      drive(1'b1, 2 * OS);
      chk("pre reset req", RCV_REQ, 1);
      drive(1'b0, OS);
      for (int i = 0; i < 4; i++) drive(i[0] ? 1'b0 : 1'b1, OS);
      drive(1'b1, 2);
      clr = 1'b0;
      #1;
      chk("midrst req", RCV_REQ, 0);
      chk("midrst data", RCV_DATA, 0);
      chk("midrst ovr", OVR_ERR, 0);
      chk("midrst frm", FRM_ERR, 0);
      step(3);
      clr = 1'b1;
      drive(1'b1, 2 * OS);
      chk("post reset req", RCV_REQ, 0);
      send_frame(8'h55, 1'b1);
      drive(1'b1, 2 * OS);
      expect_byte("post reset", 8'h55);
      // randomized frames against a queue of well-formed bytes
      nbad = 0;
      exp_q.delete();
      for (int i = 0; i < NR; i++) begin
         rd[i] = 8'($urandom_range(0, 255));
         rs[i] = ($urandom_range(0, 4) != 0);
         rg[i] = rs[i] ? int'($urandom_range(0, 2 * OS)) : int'($urandom_range(OS, 3 * OS));
         if (rs[i]) exp_q.push_back(rd[i]);
         else nbad++;
      end
      nfr = exp_q.size();
      f0 = frm_seen;
      fork
         for (int i = 0; i < NR; i++) begin
            send_frame(rd[i], rs[i]);
            drive(1'b1, rg[i]);
         end
         consume(nfr, NR * (FRAME + 3 * OS) + 200);
      join
      step(2 * OS);
      chk("rand frm count", frm_seen - f0, nbad);
      chk("rand leftover", exp_q.size(), 0);
      chk("rand final req", RCV_REQ, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
